apb2axi_bresp_tracker: RTL and testbench
========================================

Name: apb2axi_bresp_tracker

Overview:
- Write-response stage sitting directly downstream of the write builder's AW/W issue.
- Records the directory tag for every issued write burst, indexed by its AXI ID.
- Consumes the AXI3 B channel and owns BREADY.
- Returns one completion record per burst (tag + response) toward the gateway's completion/status path, with error accounting.

Parameters:
AXI_ID_W, 4, width of AWID/BID; tracking table depth is 2**AXI_ID_W
TAG_W, 4, directory tag width (matches package TAG_W)
ERR_CNT_W, 8, width of saturating error-response counter

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
iss_valid  in  1  write burst issued (asserted on AW handshake by write builder)
iss_ready  out  1  tracker can accept issue for iss_id
iss_id  in  AXI_ID_W  AWID of issued burst
iss_tag  in  TAG_W  directory tag of issued burst
bid  in  AXI_ID_W  AXI write response ID
bresp  in  2  AXI write response
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready
cpl_valid  out  1  completion record valid
cpl_ready  in  1  completion consumer ready
cpl_tag  out  TAG_W  tag of completed burst (0 when cpl_unexp)
cpl_resp  out  2  BRESP of completed burst
cpl_unexp  out  1  completion for an ID with no outstanding burst
outstanding_cnt  out  AXI_ID_W+1  number of bursts awaiting B
err_cnt  out  ERR_CNT_W  count of completions with bresp[1]=1, saturating
unexp_sticky  out  1  sticky flag: any unexpected BID seen
err_clr  in  1  clears err_cnt and unexp_sticky

Behaviour:
Interface
- One clock (aclk); reset is synchronous and active-high (areset).
- All state is updated on the rising edge of aclk.

Reset
- Clears all table valid bits.
- Output register is emptied: cpl_valid=0, cpl_tag=0, cpl_resp=0, cpl_unexp=0.
- outstanding_cnt=0, err_cnt=0, unexp_sticky=0.
- bready=1 and iss_ready=1 in the first cycle after reset.
- Reset mid-operation discards all outstanding entries; later B beats for them are reported as unexpected.

Tracking table
- 2**AXI_ID_W entries, each {valid, tag}.
- iss_ready = ~valid[iss_id], combinational from registered state only; no same-cycle bypass from a B clear.
- Issue handshake (iss_valid & iss_ready): valid[iss_id]<=1, tag[iss_id]<=iss_tag.
- Issue without ready is ignored; the builder must hold it.

B channel / completion output
- One-entry output register.
- bready = ~cpl_valid | cpl_ready.
- B handshake (bvalid & bready) in cycle N loads the output register, cpl_valid=1 in cycle N+1.
- Table lookup uses pre-edge state.
- If valid[bid]: cpl_tag=tag[bid], cpl_resp=bresp, cpl_unexp=0, valid[bid]<=0.
- Otherwise: cpl_tag=0, cpl_resp=bresp, cpl_unexp=1, unexp_sticky<=1; the table is unchanged.
- Output is held stable while cpl_valid & ~cpl_ready.
- Drain and reload in the same cycle give back-to-back completions at full throughput.

Simultaneous events
- Issue to ID X and B for ID Y≠X in the same cycle: both take effect.
- Issue to X while X is invalid and a B for X arrives in the same cycle: the B is unexpected, and the issue installs X.
- Issue to X while X is valid and a B for X arrives in the same cycle: the B completes X, the issue is stalled (iss_ready=0), and it is accepted the next cycle.

Counters
- outstanding_cnt: +1 on issue handshake, -1 on expected B handshake, unchanged when both occur or neither occurs.
- err_cnt: +1 when a completion is loaded with bresp[1]=1 (SLVERR/DECERR), expected or unexpected; saturates at all-ones.
- err_clr has priority over an increment in the same cycle: the result is 0, and unexp_sticky is cleared even if an unexpected B arrives that cycle.

Test Plan:
- Issue id=3 tag=5, then B bid=3 bresp=0 -> cpl_valid next cycle with tag=5, resp=0, unexp=0; outstanding_cnt 1->0.
- Issue id=2 tag=7 twice back-to-back -> second issue sees iss_ready=0 until B bid=2 handshakes; the second issue is then accepted the following cycle.
- cpl_ready=0 with a completion pending, second B presented -> bready=0 and cpl fields stable; cpl_ready=1 -> both completions emerge on consecutive cycles in order.
- B bid=9 with nothing outstanding, bresp=2 -> cpl_unexp=1, tag=0, unexp_sticky=1, err_cnt=1; err_clr -> both read 0 next cycle.
- 260 completions with bresp=3 -> err_cnt saturates at 255.
- 4 issues outstanding, areset pulsed -> outstanding_cnt=0, cpl_valid=0, iss_ready=1; a subsequent B for an old ID is flagged cpl_unexp=1.

Source files
------------

// File: rtl/apb2axi_bresp_tracker.sv
// Write-response tracker: records tag per AWID on issue, consumes the B
// channel, emits one completion record per burst with error accounting.
// Ports: aclk/areset; iss_* issue side; bid/bresp/bvalid/bready B channel;
// cpl_* completion record; outstanding_cnt, err_cnt, unexp_sticky, err_clr.
module apb2axi_bresp_tracker #(
  parameter int AXI_ID_W  = 4,
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [AXI_ID_W-1:0]  iss_id,
  input  logic [TAG_W-1:0]     iss_tag,
  input  logic [AXI_ID_W-1:0]  bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic                 cpl_valid,
  input  logic                 cpl_ready,
  output logic [TAG_W-1:0]     cpl_tag,
  output logic [1:0]           cpl_resp,
  output logic                 cpl_unexp,
  output logic [AXI_ID_W:0]    outstanding_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 unexp_sticky,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << AXI_ID_W;
  localparam logic [AXI_ID_W:0]    OUT_ONE = 1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = 1;

  logic [DEPTH-1:0] vld;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             iss_hs;
  logic             b_hs;
  logic             b_hit;
  logic             b_done;

  assign iss_ready = ~vld[iss_id];
  assign bready    = ~cpl_valid | cpl_ready;
  assign iss_hs    = iss_valid & iss_ready;
  assign b_hs      = bvalid & bready;
  assign b_hit     = vld[bid];
  assign b_done    = b_hs & b_hit;

  // An issue can only target an invalid entry and a clear only a valid
  // one, so the two writes below never hit the same entry.
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld <= '0;
    end else begin
      if (b_done) vld[bid] <= 1'b0;
      if (iss_hs) vld[iss_id] <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (iss_hs) tag_q[iss_id] <= iss_tag;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cpl_valid <= 1'b0;
      cpl_tag   <= '0;
      cpl_resp  <= '0;
      cpl_unexp <= 1'b0;
    end else if (b_hs) begin
      cpl_valid <= 1'b1;
      cpl_tag   <= b_hit ? tag_q[bid] : '0;
      cpl_resp  <= bresp;
      cpl_unexp <= ~b_hit;
    end else if (cpl_ready) begin
      cpl_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      outstanding_cnt <= '0;
    end else if (iss_hs && !b_done) begin
      outstanding_cnt <= outstanding_cnt + OUT_ONE;
    end else if (!iss_hs && b_done) begin
      outstanding_cnt <= outstanding_cnt - OUT_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset || err_clr) begin
      err_cnt <= '0;
    end else if (b_hs && bresp[1] && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset || err_clr) begin
      unexp_sticky <= 1'b0;
    end else if (b_hs && !b_hit) begin
      unexp_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb2axi_bresp_tracker.sv
// Bench for apb2axi_bresp_tracker: directed steps plus random traffic
// checked against a map/scoreboard reference model.
module tb_apb2axi_bresp_tracker;

  logic       aclk = 1'b0;
  logic       areset = 1'b0;
  logic       iss_valid = 1'b0;
  logic       iss_ready;
  logic [3:0] iss_id = '0;
  logic [3:0] iss_tag = '0;
  logic [3:0] bid = '0;
  logic [1:0] bresp = '0;
  logic       bvalid = 1'b0;
  logic       bready;
  logic       cpl_valid;
  logic       cpl_ready = 1'b1;
  logic [3:0] cpl_tag;
  logic [1:0] cpl_resp;
  logic       cpl_unexp;
  logic [4:0] outstanding_cnt;
  logic [7:0] err_cnt;
  logic       unexp_sticky;
  logic       err_clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  logic [3:0] tagmap [int];
  bit         m_cv = 0;
  int         m_tag = 0;
  int         m_resp = 0;
  bit         m_unexp = 0;
  int         m_out = 0;
  int         m_err = 0;
  bit         m_sticky = 0;

  apb2axi_bresp_tracker dut (
    .aclk(aclk), .areset(areset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_id(iss_id), .iss_tag(iss_tag),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_tag(cpl_tag), .cpl_resp(cpl_resp), .cpl_unexp(cpl_unexp),
    .outstanding_cnt(outstanding_cnt), .err_cnt(err_cnt),
    .unexp_sticky(unexp_sticky), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", nm, obs, exp_v);
    end
  endtask

  task automatic cyc(input bit iv, input int iid, input int itg,
                     input bit bv, input int b_id, input int br,
                     input bit cr, input bit ec, input bit rst);
    bit ihs, bhs, hit;
    iss_valid = iv; iss_id = iid[3:0]; iss_tag = itg[3:0];
    bvalid = bv; bid = b_id[3:0]; bresp = br[1:0];
    cpl_ready = cr; err_clr = ec; areset = rst;
    #1;
    if (!rst) begin
      chk("iss_ready", iss_ready, !tagmap.exists(iid));
      chk("bready", bready, !m_cv || cr);
    end
    if (rst) begin
      tagmap.delete();
      m_cv = 0; m_tag = 0; m_resp = 0; m_unexp = 0;
      m_out = 0; m_err = 0; m_sticky = 0;
    end else begin
      ihs = iv && !tagmap.exists(iid);
      bhs = bv && (!m_cv || cr);
      hit = tagmap.exists(b_id);
      if (bhs) begin
        m_cv = 1;
        m_tag = hit ? int'(tagmap[b_id]) : 0;
        m_resp = br;
        m_unexp = !hit;
        if (hit) tagmap.delete(b_id);
      end else if (cr) begin
        m_cv = 0;
      end
      if (ihs) tagmap[iid] = itg[3:0];
      m_out = m_out + int'(ihs) - int'(bhs && hit);
      if (ec) m_err = 0;
      else if (bhs && br >= 2 && m_err < 255) m_err++;
      if (ec) m_sticky = 0;
      else if (bhs && !hit) m_sticky = 1;
    end
    @(posedge aclk);
    #1;
    chk("cpl_valid", cpl_valid, m_cv);
    if (m_cv || rst) begin
      chk("cpl_tag", cpl_tag, m_tag);
      chk("cpl_resp", cpl_resp, m_resp);
      chk("cpl_unexp", cpl_unexp, m_unexp);
    end
    chk("outstanding", outstanding_cnt, m_out);
    chk("err_cnt", err_cnt, m_err);
    chk("sticky", unexp_sticky, m_sticky);
    @(negedge aclk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic iss(input int id, input int tg);
    cyc(1, id, tg, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic bch(input int id, input int r, input bit cr);
    cyc(0, 0, 0, 1, id, r, cr, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_out", outstanding_cnt, 0);
    idle();

    // basic issue/complete
    iss(3, 5);
    chk("t1_out1", outstanding_cnt, 1);
    bch(3, 0, 1);
    chk("t1_tag", cpl_tag, 5);
    chk("t1_unexp", cpl_unexp, 0);
    chk("t1_out0", outstanding_cnt, 0);
    idle();

    // duplicate issue stalls until B for the id
    iss(2, 7);
    iss(2, 7);
    chk("t2_stall_out", outstanding_cnt, 1);
    cyc(1, 2, 7, 1, 2, 0, 1, 0, 0);
    chk("t2_cpl_tag", cpl_tag, 7);
    iss(2, 7);
    chk("t2_reissue_out", outstanding_cnt, 1);
    bch(2, 1, 1);
    idle();

    // backpressure on completion output
    iss(1, 10);
    iss(4, 12);
    bch(1, 0, 0);
    bch(4, 2, 0);
    chk("t3_bready", bready, 0);
    chk("t3_hold_tag", cpl_tag, 10);
    bch(4, 2, 1);
    chk("t3_second_tag", cpl_tag, 12);
    idle();
    chk("t3_drained", cpl_valid, 0);

    // unexpected B and error clear
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    bch(9, 2, 1);
    chk("t4_unexp", cpl_unexp, 1);
    chk("t4_err", err_cnt, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("t4_clr_err", err_cnt, 0);
    chk("t4_clr_sticky", unexp_sticky, 0);
    // clear wins over a concurrent unexpected B
    cyc(0, 0, 0, 1, 9, 3, 1, 1, 0);
    chk("t4_clr_prio", unexp_sticky, 0);

    // error counter saturation
    for (int i = 0; i < 260; i++) bch(9, 3, 1);
    chk("t5_sat", err_cnt, 255);
    idle();

    // reset mid-operation
    iss(0, 1);
    iss(5, 2);
    iss(6, 3);
    iss(7, 4);
    chk("t6_out4", outstanding_cnt, 4);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("t6_rst_out", outstanding_cnt, 0);
    bch(5, 0, 1);
    chk("t6_old_unexp", cpl_unexp, 1);
    idle();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15),
          $urandom_range(0, 2) != 0, $urandom_range(0, 4),
          $urandom_range(0, 3), $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
